// File: rtl/mem_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_req_arbiter
//  Description : Two-requester arbiter in front of a single shared memory
//                port. Grants one cache-line request at a time, alternating
//                under contention. Each transaction runs IDLE -> BUSY -> DONE.
//                Optional feature macro: MEM_ARB_TIMEOUT_EN (bounds the wait
//                for mem_ready to TIMEOUT_CYCLES BUSY cycles).
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_req_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int LINE_W         = 128,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic              req0_rw,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [LINE_W-1:0] req0_data,
    input  logic              req1_valid,
    input  logic              req1_rw,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [LINE_W-1:0] req1_data,
    output logic              res0_ready,
    output logic              res0_err,
    output logic [LINE_W-1:0] res0_data,
    output logic              res1_ready,
    output logic              res1_err,
    output logic [LINE_W-1:0] res1_data,
    output logic              mem_valid,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [LINE_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                owner_q, owner_d;
    logic                last_q, last_d;
    logic                rw_q, rw_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LINE_W-1:0]   wdata_q, wdata_d;
    logic [LINE_W-1:0]   res0_data_q, res0_data_d;
    logic [LINE_W-1:0]   res1_data_q, res1_data_d;
    logic                w_grant;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int              CNT_W      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] C_TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
`endif

    // Lone requester wins; under contention the one not served last wins.
    assign w_grant = req1_valid & (~req0_valid | ~last_q);

    // Next-state, capture and completion logic.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        rw_d        = rw_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        res0_data_d = res0_data_q;
        res1_data_d = res1_data_q;
`ifdef MEM_ARB_TIMEOUT_EN
        cnt_d       = cnt_q;
        err_d       = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req0_valid || req1_valid) begin
                    state_d = S_BUSY;
                    owner_d = w_grant;
                    rw_d    = w_grant ? req1_rw   : req0_rw;
                    addr_d  = w_grant ? req1_addr : req0_addr;
                    wdata_d = w_grant ? req1_data : req0_data;
`ifdef MEM_ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            S_BUSY: begin
                if (mem_ready) begin
                    // Read data is captured even for writes; owner gets it.
                    state_d = S_DONE;
                    last_d  = owner_q;
                    if (owner_q) res1_data_d = mem_rdata;
                    else         res0_data_d = mem_rdata;
`ifdef MEM_ARB_TIMEOUT_EN
                    err_d   = 1'b0;
                end else if (cnt_q == C_TMO_LAST) begin
                    // Final permitted BUSY cycle expired: complete with error,
                    // leaving the owner's data register untouched.
                    state_d = S_DONE;
                    last_d  = owner_q;
                    err_d   = 1'b1;
                    cnt_d   = cnt_q + CNT_W'(1);
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
`endif
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            owner_q     <= 1'b0;
            last_q      <= 1'b1;
            rw_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            res0_data_q <= '0;
            res1_data_q <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            cnt_q       <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            rw_q        <= rw_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            res0_data_q <= res0_data_d;
            res1_data_q <= res1_data_d;
`ifdef MEM_ARB_TIMEOUT_EN
            cnt_q       <= cnt_d;
            err_q       <= err_d;
`endif
        end
    end

    assign mem_valid  = (state_q == S_BUSY);
    assign mem_rw     = rw_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;

    assign res0_ready = (state_q == S_DONE) & ~owner_q;
    assign res1_ready = (state_q == S_DONE) &  owner_q;
    assign res0_data  = res0_data_q;
    assign res1_data  = res1_data_q;

`ifdef MEM_ARB_TIMEOUT_EN
    assign res0_err   = res0_ready & err_q;
    assign res1_err   = res1_ready & err_q;
`else
    // No timeout: the error flag can never be raised. The comparison is a
    // constant 0 that keeps TIMEOUT_CYCLES referenced in this build.
    assign res0_err   = (TIMEOUT_CYCLES < 0);
    assign res1_err   = (TIMEOUT_CYCLES < 0);
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_req_arbiter
//  Description : Self-checking bench for mem_req_arbiter: vector table,
//                directed corner sequences and a randomized run against a
//                transaction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_req_arbiter;

    localparam int AW  = 32;
    localparam int LW  = 128;
    localparam int TMO = 8;
`ifdef MEM_ARB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req0_rw, req1_valid, req1_rw;
    logic [AW-1:0] req0_addr, req1_addr;
    logic [LW-1:0] req0_data, req1_data;
    logic          res0_ready, res0_err, res1_ready, res1_err;
    logic [LW-1:0] res0_data, res1_data;
    logic          mem_valid, mem_rw, mem_ready;
    logic [AW-1:0] mem_addr;
    logic [LW-1:0] mem_wdata, mem_rdata;

    int total = 0;
    int bad   = 0;

    mem_req_arbiter #(.ADDR_W(AW), .LINE_W(LW), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_rw(req0_rw), .req0_addr(req0_addr), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_rw(req1_rw), .req1_addr(req1_addr), .req1_data(req1_data),
        .res0_ready(res0_ready), .res0_err(res0_err), .res0_data(res0_data),
        .res1_ready(res1_ready), .res1_err(res1_err), .res1_data(res1_data),
        .mem_valid(mem_valid), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; req0_rw = 1'b0; req1_rw = 1'b0;
        req0_addr = '0; req1_addr = '0; req0_data = '0; req1_data = '0;
        mem_ready = 1'b0; mem_rdata = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Vector table
    // ------------------------------------------------------------------
    typedef struct {
        logic          rst, v0, v1, rw0, mr;
        logic [AW-1:0] a0, a1;
        logic [LW-1:0] rd;
        logic          e_mv, e_r0, e_r1;
        logic [AW-1:0] e_addr;
        logic [LW-1:0] e_d0, e_d1;
    } vec_t;

    function automatic vec_t mk(logic r, logic v0, logic v1, logic rw0, logic [AW-1:0] a0,
                                logic [AW-1:0] a1, logic mr, logic [LW-1:0] rd, logic e_mv,
                                logic [AW-1:0] e_addr, logic e_r0, logic e_r1,
                                logic [LW-1:0] e_d0, logic [LW-1:0] e_d1);
        vec_t v;
        v.rst = r; v.v0 = v0; v.v1 = v1; v.rw0 = rw0; v.a0 = a0; v.a1 = a1; v.mr = mr; v.rd = rd;
        v.e_mv = e_mv; v.e_addr = e_addr; v.e_r0 = e_r0; v.e_r1 = e_r1; v.e_d0 = e_d0; v.e_d1 = e_d1;
        return v;
    endfunction

    // ------------------------------------------------------------------
    // Transaction-level reference model
    // ------------------------------------------------------------------
    typedef struct {
        int            who;
        logic          rw;
        logic [AW-1:0] addr;
        logic [LW-1:0] data;
    } txn_t;

    txn_t          inflight[$];
    int            pulse_to;
    int            last_who;
    int            waited;
    logic          m_err;
    logic [LW-1:0] m_d [2];

    task automatic model_finish(input logic err);
        pulse_to = inflight[0].who;
        last_who = inflight[0].who;
        m_err    = err;
        void'(inflight.pop_front());
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        txn_t t;
        if (rst) begin
            inflight.delete();
            pulse_to = -1; last_who = 1; m_err = 1'b0; m_d[0] = '0; m_d[1] = '0;
        end else if (pulse_to >= 0) begin
            pulse_to = -1;
        end else if (inflight.size() > 0) begin
            if (mem_ready) begin
                m_d[inflight[0].who] = mem_rdata;
                model_finish(1'b0);
            end else if (TMO_EN && (waited + 1 == TMO)) begin
                model_finish(1'b1);
            end else begin
                waited++;
            end
        end else if (req0_valid || req1_valid) begin
            if (req0_valid && req1_valid) t.who = 1 - last_who;
            else                          t.who = req1_valid ? 1 : 0;
            t.rw   = t.who ? req1_rw   : req0_rw;
            t.addr = t.who ? req1_addr : req0_addr;
            t.data = t.who ? req1_data : req0_data;
            inflight.push_back(t);
            waited = 0;
        end
    endtask

    task automatic model_compare();
        chk("rnd mem_valid", mem_valid, inflight.size() > 0);
        if (inflight.size() > 0) begin
            chk("rnd mem_rw",    mem_rw,    inflight[0].rw);
            chk("rnd mem_addr",  mem_addr,  inflight[0].addr);
            chk("rnd mem_wdata", mem_wdata, inflight[0].data);
        end
        chk("rnd res0_ready", res0_ready, pulse_to == 0);
        chk("rnd res1_ready", res1_ready, pulse_to == 1);
        if (pulse_to == 0) chk("rnd res0_err", res0_err, m_err);
        if (pulse_to == 1) chk("rnd res1_err", res1_err, m_err);
        chk("rnd res0_data", res0_data, m_d[0]);
        chk("rnd res1_data", res1_data, m_d[1]);
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    vec_t          vecs[$];
    logic [LW-1:0] a5;
    logic [AW-1:0] exp_addr;
    int            n;
    bit            pend0, pend1;

    initial begin
        idle_inputs();
        rst = 1'b1;
        a5 = {16{8'hA5}};

        // ---- table-driven vectors: single read, contention, ignored mem_ready
        vecs.push_back(mk(1,0,0,0,32'h0,        32'h0,  0,'0,     0,32'h0,        0,0,'0,    '0));
        vecs.push_back(mk(0,1,0,0,32'h80004000, 32'h0,  0,'0,     1,32'h80004000, 0,0,'0,    '0));
        vecs.push_back(mk(0,1,0,0,32'h80004000, 32'h0,  0,'0,     1,32'h80004000, 0,0,'0,    '0));
        vecs.push_back(mk(0,1,0,0,32'h80004000, 32'h0,  0,'0,     1,32'h80004000, 0,0,'0,    '0));
        vecs.push_back(mk(0,1,0,0,32'h80004000, 32'h0,  1,a5,     0,32'h0,        1,0,a5,    '0));
        vecs.push_back(mk(0,0,0,0,32'h0,        32'h0,  0,'0,     0,32'h0,        0,0,a5,    '0));
        vecs.push_back(mk(1,0,0,0,32'h0,        32'h0,  0,'0,     0,32'h0,        0,0,'0,    '0));
        vecs.push_back(mk(0,1,1,0,32'h100,      32'h200,0,'0,     1,32'h100,      0,0,'0,    '0));
        vecs.push_back(mk(0,1,1,0,32'h100,      32'h200,1,128'h11,0,32'h0,        1,0,128'h11,'0));
        vecs.push_back(mk(0,1,1,0,32'h100,      32'h200,0,'0,     0,32'h0,        0,0,128'h11,'0));
        vecs.push_back(mk(0,1,1,0,32'h100,      32'h200,0,'0,     1,32'h200,      0,0,128'h11,'0));
        vecs.push_back(mk(0,1,1,0,32'h100,      32'h200,1,128'h22,0,32'h0,        0,1,128'h11,128'h22));
        vecs.push_back(mk(0,0,0,0,32'h0,        32'h0,  0,'0,     0,32'h0,        0,0,128'h11,128'h22));
        vecs.push_back(mk(0,0,0,0,32'h0,        32'h0,  1,'1,     0,32'h0,        0,0,128'h11,128'h22));

        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst; req0_valid = vecs[i].v0; req1_valid = vecs[i].v1;
            req0_rw = vecs[i].rw0; req0_addr = vecs[i].a0; req1_addr = vecs[i].a1;
            mem_ready = vecs[i].mr; mem_rdata = vecs[i].rd;
            cyc();
            chk($sformatf("vec%0d mem_valid", i), mem_valid, vecs[i].e_mv);
            if (vecs[i].e_mv) chk($sformatf("vec%0d mem_addr", i), mem_addr, vecs[i].e_addr);
            chk($sformatf("vec%0d res0_ready", i), res0_ready, vecs[i].e_r0);
            chk($sformatf("vec%0d res1_ready", i), res1_ready, vecs[i].e_r1);
            chk($sformatf("vec%0d res0_data", i), res0_data, vecs[i].e_d0);
            chk($sformatf("vec%0d res1_data", i), res1_data, vecs[i].e_d1);
            if (i == 0) begin
                chk("reset mem_rw", mem_rw, 1'b0);
                chk("reset mem_wdata", mem_wdata, '0);
                chk("reset res0_err", res0_err, 1'b0);
                chk("reset res1_err", res1_err, 1'b0);
            end
        end

        // ---- alternation: both held valid, owner order 0,1,0,1
        do_reset();
        req0_valid = 1'b1; req1_valid = 1'b1; req0_addr = 32'hA0; req1_addr = 32'hB0;
        for (int t = 0; t < 4; t++) begin
            n = 0;
            cyc();
            while (!mem_valid && n < 8) begin
                cyc();
                n++;
            end
            chk($sformatf("alt%0d mem_valid", t), mem_valid, 1'b1);
            exp_addr = (t % 2 == 0) ? 32'hA0 : 32'hB0;
            chk($sformatf("alt%0d mem_addr", t), mem_addr, exp_addr);
            mem_ready = 1'b1; mem_rdata = LW'(t + 1);
            cyc();
            mem_ready = 1'b0;
            chk($sformatf("alt%0d res0_ready", t), res0_ready, (t % 2) == 0);
            chk($sformatf("alt%0d res1_ready", t), res1_ready, (t % 2) == 1);
        end

        // ---- write capture: requester inputs change during BUSY
        do_reset();
        req1_valid = 1'b1; req1_rw = 1'b1; req1_addr = 32'h80004008; req1_data = 128'h89ABCDEF;
        cyc();
        req1_rw = 1'b0; req1_addr = 32'h1234; req1_data = '1;
        req0_valid = 1'b1; req0_rw = 1'b0; req0_addr = 32'h5678;
        cyc();
        chk("wr mem_valid", mem_valid, 1'b1);
        chk("wr mem_rw",    mem_rw,    1'b1);
        chk("wr mem_addr",  mem_addr,  32'h80004008);
        chk("wr mem_wdata", mem_wdata, 128'h89ABCDEF);
        mem_ready = 1'b1; mem_rdata = 128'h77;
        cyc();
        mem_ready = 1'b0; req1_valid = 1'b0; req0_valid = 1'b0;
        chk("wr res1_ready", res1_ready, 1'b1);
        chk("wr res0_ready", res0_ready, 1'b0);
        chk("wr res1_data",  res1_data,  128'h77);
        cyc();

        // ---- reset mid-BUSY
        do_reset();
        req0_valid = 1'b1; req0_addr = 32'h300;
        cyc();
        req0_valid = 1'b0;
        cyc();
        chk("rstb busy mem_valid", mem_valid, 1'b1);
        rst = 1'b1;
        cyc();
        chk("rstb mem_valid", mem_valid, 1'b0);
        rst = 1'b0; mem_ready = 1'b1;
        cyc();
        chk("rstb res0_ready", res0_ready, 1'b0);
        chk("rstb res1_ready", res1_ready, 1'b0);
        chk("rstb idle mem_valid", mem_valid, 1'b0);
        mem_ready = 1'b0; req0_valid = 1'b1; req0_addr = 32'h304;
        cyc();
        chk("rstb again mem_valid", mem_valid, 1'b1);
        chk("rstb again mem_addr", mem_addr, 32'h304);
        req0_valid = 1'b0; mem_ready = 1'b1; mem_rdata = 128'h3C;
        cyc();
        mem_ready = 1'b0;
        chk("rstb again res0_ready", res0_ready, 1'b1);
        chk("rstb again res0_data", res0_data, 128'h3C);
        cyc();

`ifdef MEM_ARB_TIMEOUT_EN
        // ---- timeout: no mem_ready for TMO BUSY cycles
        do_reset();
        req0_valid = 1'b1; req0_addr = 32'h400;
        cyc();
        req0_valid = 1'b0;
        for (int i = 1; i <= TMO; i++) begin
            chk($sformatf("tmo busy%0d mem_valid", i), mem_valid, 1'b1);
            if (i < TMO) cyc();
        end
        cyc();
        chk("tmo res0_ready", res0_ready, 1'b1);
        chk("tmo res0_err",   res0_err,   1'b1);
        chk("tmo res0_data",  res0_data,  '0);
        chk("tmo mem_valid",  mem_valid,  1'b0);
        cyc();
        // ---- mem_ready on the terminal cycle is a normal completion
        req0_valid = 1'b1;
        cyc();
        req0_valid = 1'b0;
        for (int i = 1; i < TMO; i++) cyc();
        chk("tmo8 mem_valid", mem_valid, 1'b1);
        mem_ready = 1'b1; mem_rdata = 128'h5A;
        cyc();
        mem_ready = 1'b0;
        chk("tmo8 res0_ready", res0_ready, 1'b1);
        chk("tmo8 res0_err",   res0_err,   1'b0);
        chk("tmo8 res0_data",  res0_data,  128'h5A);
        cyc();
`else
        // ---- no timeout: BUSY waits indefinitely
        do_reset();
        req0_valid = 1'b1; req0_addr = 32'h400;
        cyc();
        req0_valid = 1'b0;
        for (int i = 0; i < 3 * TMO; i++) begin
            if (!mem_valid || res0_ready) begin
                chk("wait mem_valid", mem_valid, 1'b1);
                chk("wait res0_ready", res0_ready, 1'b0);
            end
            cyc();
        end
        chk("wait end mem_valid", mem_valid, 1'b1);
        mem_ready = 1'b1; mem_rdata = 128'h5A;
        cyc();
        mem_ready = 1'b0;
        chk("wait res0_ready", res0_ready, 1'b1);
        chk("wait res0_err",   res0_err,   1'b0);
        cyc();
`endif

        // ---- randomized run against the reference model
        idle_inputs();
        rst = 1'b1;
        model_step();
        cyc();
        model_compare();
        pend0 = 1'b0; pend1 = 1'b0;
        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(0, 63) == 0);
            if (!pend0 && $urandom_range(0, 3) == 0) pend0 = 1'b1;
            if (!pend1 && $urandom_range(0, 3) == 0) pend1 = 1'b1;
            req0_valid = pend0; req1_valid = pend1;
            req0_rw = 1'($urandom); req1_rw = 1'($urandom);
            req0_addr = $urandom; req1_addr = $urandom;
            req0_data = {$urandom, $urandom, $urandom, $urandom};
            req1_data = {$urandom, $urandom, $urandom, $urandom};
            mem_ready = ($urandom_range(0, 2) == 0);
            mem_rdata = {$urandom, $urandom, $urandom, $urandom};
            model_step();
            cyc();
            model_compare();
            if (res0_ready) pend0 = 1'b0;
            if (res1_ready) pend1 = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_req_arbiter.md
MEM_REQ_ARBITER -- requirements
Module: mem_req_arbiter

Interface
REQ-001 The block SHALL have a single clock `clk` and a synchronous, active-high reset `rst`.
REQ-002 Parameter ADDR_W, default 32, is the address width.
REQ-003 Parameter LINE_W, default 128, is the cache-line data width.
REQ-004 Parameter TIMEOUT_CYCLES, default 64, sets the maximum number of cycles waiting for memory; it is used only with MEM_ARB_TIMEOUT_EN.
REQ-005 Ports SHALL be, in order:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- reqN_valid  in  1  requester N (N=0,1) has a memory request pending.
- reqN_rw  in  1  requester N: 0=read line, 1=write line.
- reqN_addr  in  ADDR_W  requester N line address.
- reqN_data  in  LINE_W  requester N write line.
- resN_ready  out  1  one-cycle completion pulse to requester N.
- resN_err  out  1  completion was a timeout; qualified by resN_ready.
- resN_data  out  LINE_W  read line returned to requester N.
- mem_valid  out  1  request to shared memory.
- mem_rw  out  1  memory op.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  LINE_W  memory write line.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_rdata  in  LINE_W  memory read line, valid with mem_ready.

Function
REQ-006 The FSM SHALL have states IDLE, BUSY and DONE, plus an owner bit and a last-served bit.
REQ-007 In IDLE with any reqN_valid, the next state SHALL be BUSY.
- Only one requester valid: that requester is granted.
- Both valid: the requester that is not last-served is granted.
- The grant is latched into owner; reqN_rw/addr/data of the granted requester are captured into internal registers.
REQ-008 In BUSY, mem_valid SHALL be 1 and mem_rw/mem_addr/mem_wdata SHALL be driven from the captured registers; requester input changes are ignored.
- Latency: valid sampled at edge k gives mem_valid high in cycle k+1.
REQ-009 In BUSY with mem_ready=1, the next state SHALL be DONE.
- resN_data for the owner is registered from mem_rdata (write ops: mem_rdata captured regardless).
- last-served is set to owner.
REQ-010 In DONE, the block SHALL:
- drive resN_ready=1 for the owner only, for exactly one cycle;
- drive mem_valid=0;
- take next state IDLE unconditionally.
This dead cycle lets the requester drop valid; a request still held in IDLE is treated as new.
REQ-011 mem_ready outside BUSY SHALL be ignored.
REQ-012 resN_data SHALL hold its value until the next completion to N.
REQ-013 No request is lost: a requester held valid while the other is served SHALL be granted at the next IDLE.

Reset
REQ-014 On rst, the block SHALL set:
- state=IDLE, owner=0, last-served=1 (req0 wins first contention);
- all resN_ready/resN_err=0, resN_data=0;
- mem_valid=0, mem_rw=0, mem_addr=0, mem_wdata=0;
- timeout counter=0.
REQ-015 Reset mid-BUSY or mid-DONE SHALL abandon the transaction: mem_valid=0 in the following cycle and no resN_ready pulse.

Configuration
REQ-016 With macro MEM_ARB_TIMEOUT_EN defined, a counter of width $clog2(TIMEOUT_CYCLES+1) SHALL:
- clear on entry to BUSY and increment each BUSY cycle without mem_ready;
- on reaching TIMEOUT_CYCLES, force DONE with resN_err=1 and resN_data unchanged;
- if mem_ready coincides with the terminal count, the cycle is a normal completion (err=0).
REQ-017 Without MEM_ARB_TIMEOUT_EN, no counter exists, resN_err is tied 0, and BUSY waits indefinitely.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- Single read: req0 rd 0x80004000, mem_ready 3 cycles later with rdata=0xA5..A5 -> res0_ready one pulse, res0_data=0xA5..A5, res1_ready stays 0.
- Contention after reset: req0 and req1 both valid on the same edge -> req0 served first, then req1 granted at the next IDLE; mem_addr matches each requester.
- Alternation: both held continuously valid for 4 transactions -> owner order 0,1,0,1.
- Write capture: req1 wr addr 0x80004008, data 0x89ABCDEF; requester inputs change during BUSY -> mem_addr/mem_wdata keep the captured values.
- Reset mid-BUSY: rst pulsed before mem_ready -> mem_valid=0 next cycle, no res pulse, later request proceeds normally.
- Timeout (macro defined, TIMEOUT_CYCLES=8): mem_ready never asserted -> res0_ready and res0_err=1 after 8 BUSY cycles; mem_ready on cycle 8 -> err=0.
